// File: rtl/gate_tt_pkg.sv
// Shared definitions for the 2-input gate truth-table sequencer:
// state encoding, reference truth tables and the sweep result record.
package gate_tt_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_APPLY  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    APPLY  = ST_APPLY,
    WAIT   = ST_WAIT,
    SAMPLE = ST_SAMPLE,
    REPORT = ST_REPORT
  } state_t;

  // Bit i is the gate output for {in1,in2} == i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // Result of one sweep, as presented on the output ports.
  typedef struct packed {
    logic [3:0] observed;
    logic [3:0] fail_mask;
    logic       pass;
  } tt_result_t;

endpackage

// File: rtl/gate_tt_sequencer_settle_timer.sv
// Settle timer: 4-bit up-counter, cleared on entry to a vector and run while
// waiting; tc flags the last wait cycle so the FSM leaves WAIT after exactly
// SETTLE_CYCLES cycles.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [3:0] cnt;

  // Count wait cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 4'd1;
  end

  // cnt is 0 on the first wait cycle, so the terminal cycle is SETTLE_CYCLES-1.
  assign tc = ({1'b0, cnt} + 5'd1) == 5'(SETTLE_CYCLES);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Self-test sequencer for a 2-input combinational gate: drives the four input
// vectors in order 00,01,10,11, lets each settle, samples the gate output and
// compares the captured truth table against the one latched at start.
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] observed,
  output logic [3:0] fail_mask
);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] exp_q;
  logic       tc;
  tt_result_t res;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == APPLY),
    .en    (state == WAIT),
    .tc    (tc)
  );

  // Sweep FSM with registered gate inputs, status and results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      exp_q <= '0;
      in1   <= 1'b0;
      in2   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Expected table is frozen here; later changes cannot affect the verdict.
            exp_q <= expected;
            idx   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= APPLY;
          end
        end
        APPLY: begin
          {in1, in2} <= idx;
          state      <= (SETTLE_CYCLES == 0) ? SAMPLE : WAIT;
        end
        WAIT: begin
          if (tc) state <= SAMPLE;
        end
        SAMPLE: begin
          res.observed[idx] <= gate_out;
          if (idx == 2'd3) begin
            state <= REPORT;
          end else begin
            idx   <= idx + 2'd1;
            state <= APPLY;
          end
        end
        REPORT: begin
          done          <= 1'b1;
          res.fail_mask <= res.observed ^ exp_q;
          res.pass      <= (res.observed == exp_q);
          in1           <= 1'b0;
          in2           <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pass      = res.pass;
  assign observed  = res.observed;
  assign fail_mask = res.fail_mask;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: an OR gate under test, a default build and a
// zero-settle build, expected sweep results queued at start and popped on done.
module tb_gate_tt_sequencer;
  import gate_tt_pkg::*;

  logic clk;
  logic rst_n, rst0_n;
  logic start, start0;
  logic [3:0] expected, expected0;
  logic gate_out, gate_out0;
  logic in1, in2, busy, done, pass;
  logic [3:0] observed, fail_mask;
  logic in1_0, in2_0, busy0, done0, pass0;
  logic [3:0] observed0, fail_mask0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] obs;
    logic [3:0] fm;
    logic       pass;
  } exp_t;
  exp_t sbq[$];

  // OR gate under test for each sequencer
  assign gate_out  = in1 | in2;
  assign gate_out0 = in1_0 | in2_0;

  gate_tt_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .gate_out(gate_out),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .pass(pass),
    .observed(observed), .fail_mask(fail_mask)
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .expected(expected0), .gate_out(gate_out0),
    .in1(in1_0), .in2(in2_0), .busy(busy0), .done(done0), .pass(pass0),
    .observed(observed0), .fail_mask(fail_mask0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected sweep result for an OR gate against table e.
  function automatic exp_t model_or(input logic [3:0] e);
    exp_t r;
    for (int i = 0; i < 4; i++) r.obs[i] = i[1] | i[0];
    r.fm   = r.obs ^ e;
    r.pass = (r.obs == e);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rst0_n = 1'b0; start = 1'b0; start0 = 1'b0;
    expected = 4'h0; expected0 = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({in1, in2} !== 2'b00) begin n_bad++; $display("FAIL reset_in: got %b want 00", {in1, in2}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %b want 0", pass); end
    n_cmp++; if (observed !== 4'h0) begin n_bad++; $display("FAIL reset_observed: got %h want 0", observed); end
    n_cmp++; if (fail_mask !== 4'h0) begin n_bad++; $display("FAIL reset_fail_mask: got %h want 0", fail_mask); end
    n_cmp++; if ({busy0, done0, pass0, observed0, fail_mask0, in1_0, in2_0} !== 13'h0) begin
      n_bad++; $display("FAIL reset_dut0: got %h want 0", {busy0, done0, pass0, observed0, fail_mask0, in1_0, in2_0});
    end
    rst_n = 1'b1; rst0_n = 1'b1;
    @(negedge clk);
  endtask

  // One full sweep on the default build; checks vector order, latency, results.
  task automatic do_sweep(input string tag, input logic [3:0] e);
    exp_t x;
    logic [7:0] seq;
    logic [1:0] last;
    int nseq, lat;
    seq = '0; last = 2'b00; nseq = 0; lat = -1;
    expected = e; start = 1'b1;
    sbq.push_back(model_or(e));
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy && (nseq == 0 || {in1, in2} != last)) begin
        if (nseq < 4) seq[2*nseq +: 2] = {in1, in2};
        nseq++;
        last = {in1, in2};
      end
      if (done) begin lat = k; break; end
    end
    x = sbq.pop_front();
    n_cmp++;
    if (lat < 0) begin
      n_bad++; $display("FAIL %s_timeout: no done within 60 cycles", tag);
    end else begin
      if (lat != 17) begin n_bad++; $display("FAIL %s_latency: got %0d want 17", tag, lat); end
      n_cmp++; if (nseq != 4 || seq !== 8'he4) begin n_bad++; $display("FAIL %s_vectors: got %h (%0d) want e4 (4)", tag, seq, nseq); end
      n_cmp++; if (observed !== x.obs) begin n_bad++; $display("FAIL %s_observed: got %b want %b", tag, observed, x.obs); end
      n_cmp++; if (pass !== x.pass) begin n_bad++; $display("FAIL %s_pass: got %b want %b", tag, pass, x.pass); end
      n_cmp++; if (fail_mask !== x.fm) begin n_bad++; $display("FAIL %s_fail_mask: got %b want %b", tag, fail_mask, x.fm); end
      n_cmp++; if (busy !== 1'b0 || {in1, in2} !== 2'b00) begin n_bad++; $display("FAIL %s_idle: got busy=%b in=%b want 0 00", tag, busy, {in1, in2}); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse: got %b want 0", tag, done); end
      n_cmp++; if (observed !== x.obs) begin n_bad++; $display("FAIL %s_hold: got %b want %b", tag, observed, x.obs); end
    end
  endtask

  task automatic test_or();  do_sweep("or",  TT_OR);  endtask
  task automatic test_and(); do_sweep("and", TT_AND); endtask

  task automatic test_settle0();
    exp_t x;
    int lat;
    lat = -1;
    expected0 = TT_OR; start0 = 1'b1;
    sbq.push_back(model_or(TT_OR));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) start0 = 1'b0;
      if (done0) begin lat = k; break; end
    end
    x = sbq.pop_front();
    n_cmp++;
    if (lat != 9) begin n_bad++; $display("FAIL s0_latency: got %0d want 9", lat); end
    n_cmp++; if (observed0 !== x.obs) begin n_bad++; $display("FAIL s0_observed: got %b want %b", observed0, x.obs); end
    n_cmp++; if (pass0 !== x.pass) begin n_bad++; $display("FAIL s0_pass: got %b want %b", pass0, x.pass); end
    n_cmp++; if (fail_mask0 !== x.fm) begin n_bad++; $display("FAIL s0_fail_mask: got %b want %b", fail_mask0, x.fm); end
    @(negedge clk);
  endtask

  // Extra starts mid-sweep and in REPORT, plus a mid-sweep expected change.
  task automatic test_ignore_start();
    exp_t x;
    int nd, lat;
    nd = 0; lat = -1;
    expected = TT_OR; start = 1'b1;
    sbq.push_back(model_or(TT_OR));
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 16);
      if (k == 3) expected = TT_AND;
      if (done) begin
        nd++;
        if (nd == 1) begin
          lat = k;
          x = sbq.pop_front();
          n_cmp++; if (pass !== x.pass) begin n_bad++; $display("FAIL ign_pass: got %b want %b", pass, x.pass); end
          n_cmp++; if (fail_mask !== x.fm) begin n_bad++; $display("FAIL ign_fail_mask: got %b want %b", fail_mask, x.fm); end
        end
      end
    end
    start = 1'b0;
    n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", nd); end
    n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL ign_latency: got %0d want 17", lat); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy: got %b want 0", busy); end
  endtask

  // Reset during WAIT of vector 2 aborts the sweep without a done pulse.
  task automatic test_reset_midsweep();
    int nd;
    nd = 0;
    expected = TT_OR; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (done) nd++;
      if (k == 9) begin
        n_cmp++; if (!busy || {in1, in2} !== 2'b10) begin n_bad++; $display("FAIL rst_pre: got busy=%b in=%b want 1 10", busy, {in1, in2}); end
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    if (done) nd++;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({in1, in2} !== 2'b00) begin n_bad++; $display("FAIL rst_in: got %b want 00", {in1, in2}); end
    n_cmp++; if (observed !== 4'h0) begin n_bad++; $display("FAIL rst_observed: got %b want 0000", observed); end
    n_cmp++; if (pass !== 1'b0 || fail_mask !== 4'h0) begin n_bad++; $display("FAIL rst_result: got pass=%b fm=%b want 0 0000", pass, fail_mask); end
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_cmp++; if (nd != 0) begin n_bad++; $display("FAIL rst_no_done: got %0d want 0", nd); end
    do_sweep("post_rst", TT_XOR);
  endtask

  // start held high: sweeps run back to back, results cleared on each accept.
  task automatic test_back_to_back();
    exp_t x;
    int nd, d1, d2;
    nd = 0; d1 = -1; d2 = -1;
    expected = TT_OR; start = 1'b1;
    sbq.push_back(model_or(TT_OR));
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 18) begin
        n_cmp++; if (!busy || observed !== 4'h0 || pass !== 1'b0) begin
          n_bad++; $display("FAIL b2b_clear: got busy=%b obs=%b pass=%b want 1 0000 0", busy, observed, pass);
        end
      end
      if (done) begin
        nd++;
        if (sbq.size() > 0) begin
          x = sbq.pop_front();
          n_cmp++; if (observed !== x.obs || pass !== x.pass || fail_mask !== x.fm) begin
            n_bad++; $display("FAIL b2b_result%0d: got %b/%b/%b want %b/%b/%b", nd, observed, pass, fail_mask, x.obs, x.pass, x.fm);
          end
        end
        if (nd == 1) begin
          d1 = k;
          expected = TT_XOR;
          sbq.push_back(model_or(TT_XOR));
        end else begin
          if (nd == 2) d2 = k;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++; if (nd != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    n_cmp++; if (d1 != 17 || d2 != 35) begin n_bad++; $display("FAIL b2b_timing: got %0d,%0d want 17,35", d1, d2); end
  endtask

  initial begin
    test_reset();
    test_or();
    test_and();
    test_settle0();
    test_ignore_start();
    test_reset_midsweep();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
